// File: rtl/am_dac_sequencer.sv
// AM DAC carrier modulator sequencer: accepts clamped distance samples, slew-limits the
// applied envelope per update tick, and sequences modulator enable through warm-up/track/mute.
module am_dac_sequencer #(
  parameter int WIDTH         = 13,
  parameter int LOG2_MAX_DIST = 11,
  parameter int TICK_DIV      = 1000,
  parameter int STEP          = 16,
  parameter int PIPE_LAT      = 2,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] in_distance,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dac_enable,
  output logic [WIDTH-1:0] dac_distance,
  output logic             am_valid,
  output logic             busy
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int WARM_W = $clog2(PIPE_LAT + 1);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [WIDTH-1:0] MAX_DIST = WIDTH'(1 << LOG2_MAX_DIST);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);

  typedef enum logic [1:0] {IDLE, WARMUP, TRACK, MUTE} state_t;

  state_t             state;
  state_t             state_next;
  logic [TICK_W-1:0]  tick_cnt;
  logic [WARM_W-1:0]  warm_cnt;
  logic [TO_W-1:0]    timeout_cnt;
  logic [WIDTH-1:0]   target;
  logic [WIDTH-1:0]   dac_level;
  logic               tick;
  logic               track_ready;
  logic               accept;
  logic               warm_done;
  logic               timeout_hit;
  logic               slew_en;

  function automatic logic [WIDTH-1:0] clamp_dist(input logic [WIDTH-1:0] d);
    return (d >= MAX_DIST) ? MAX_DIST : d;
  endfunction

  // Moves cur toward tgt by at most STEP; the min() keeps it from overshooting.
  function automatic logic [WIDTH-1:0] slew_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] diff;
    if (cur < tgt) begin
      diff = tgt - cur;
      return cur + ((diff > STEP_V) ? STEP_V : diff);
    end else begin
      diff = cur - tgt;
      return cur - ((diff > STEP_V) ? STEP_V : diff);
    end
  endfunction

  assign tick        = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign track_ready = (state == TRACK) && run;
  assign accept      = track_ready && in_valid;
  assign warm_done   = (warm_cnt == WARM_W'(PIPE_LAT - 1));
  assign timeout_hit = tick && (target != '0) && !accept &&
                       (timeout_cnt == TO_W'(TIMEOUT_TICKS - 1));
  // Dropping run in TRACK pre-empts the slew on that edge.
  assign slew_en     = tick && ((state == MUTE) || track_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = WARMUP;
      WARMUP:  if (!run) state_next = IDLE;
               else if (warm_done) state_next = TRACK;
      TRACK:   if (!run || timeout_hit) state_next = MUTE;
      MUTE:    if (dac_level == '0) state_next = run ? TRACK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      warm_cnt    <= '0;
      timeout_cnt <= '0;
      target      <= '0;
      dac_level   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      warm_cnt <= (state == WARMUP) ? warm_cnt + 1'b1 : '0;
      if ((state == TRACK) && (state_next == TRACK)) begin
        if (accept)                       timeout_cnt <= '0;
        else if (tick && (target != '0))  timeout_cnt <= timeout_cnt + 1'b1;
      end else begin
        timeout_cnt <= '0;
      end
      if ((state == TRACK) && (state_next == MUTE)) target <= '0;
      else if (accept)                              target <= clamp_dist(in_distance);
      if (slew_en) dac_level <= slew_step(dac_level, target);
    end
  end

  always_comb begin
    dac_enable = 1'b0;
    am_valid   = 1'b0;
    in_ready   = 1'b0;
    case (state)
      WARMUP: dac_enable = 1'b1;
      TRACK: begin
        dac_enable = 1'b1;
        am_valid   = 1'b1;
        in_ready   = run;
      end
      MUTE: begin
        dac_enable = 1'b1;
        am_valid   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      dac_enable = 1'b0;
      am_valid   = 1'b0;
      in_ready   = 1'b0;
    end
  end

  assign dac_distance = reset ? '0 : dac_level;
  assign busy         = !reset && (dac_level != target);

endmodule

// File: tb/tb_am_dac_sequencer.sv
// Directed bench for am_dac_sequencer with TICK_DIV=4, STEP=16, PIPE_LAT=2, TIMEOUT_TICKS=3.
module tb_am_dac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [12:0] in_distance;
  logic        in_valid;
  logic        in_ready;
  logic        dac_enable;
  logic [12:0] dac_distance;
  logic        am_valid;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int tb_cnt = 0;
  int exp_dac = 0;

  am_dac_sequencer #(
    .WIDTH(13), .LOG2_MAX_DIST(11), .TICK_DIV(4), .STEP(16), .PIPE_LAT(2), .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .in_distance(in_distance), .in_valid(in_valid),
    .in_ready(in_ready), .dac_enable(dac_enable), .dac_distance(dac_distance),
    .am_valid(am_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference tick phase: the edge after tb_cnt==3 is a tick edge.
  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic av, input logic rdy,
                            input int dac, input logic bsy);
    check({tag, ".dac_enable"},   {31'b0, dac_enable}, {31'b0, en});
    check({tag, ".am_valid"},     {31'b0, am_valid},   {31'b0, av});
    check({tag, ".in_ready"},     {31'b0, in_ready},   {31'b0, rdy});
    check({tag, ".dac_distance"}, {19'b0, dac_distance}, 32'(dac));
    check({tag, ".busy"},         {31'b0, busy},       {31'b0, bsy});
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit was;
    do begin
      was = (tb_cnt == 3);
      cyc1();
    end while (!was);
  endtask

  task automatic send(input int d);
    in_distance = 13'(d);
    in_valid    = 1'b1;
    cyc1();
    in_valid    = 1'b0;
  endtask

  // One fresh sample before each tick keeps the timeout from firing while ramping.
  task automatic track_ticks(input string tag, input int d, input int n);
    int tgt;
    int diff;
    tgt = (d >= 2048) ? 2048 : d;
    for (int i = 0; i < n; i++) begin
      send(d);
      wait_tick();
      if (exp_dac < tgt) begin
        diff = tgt - exp_dac;
        exp_dac = exp_dac + ((diff > 16) ? 16 : diff);
      end else begin
        diff = exp_dac - tgt;
        exp_dac = exp_dac - ((diff > 16) ? 16 : diff);
      end
      check(tag, {19'b0, dac_distance}, 32'(exp_dac));
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; in_valid = 1'b0; in_distance = '0;

    // Reset and warm-up
    cyc1();
    check_outs("rst_hold", 0, 0, 0, 0, 0);
    cyc1();
    cyc1();
    reset = 1'b0; run = 1'b1;
    #1;
    check_outs("rst_after", 0, 0, 0, 0, 0);
    cyc1();
    check_outs("warm1", 1, 0, 0, 0, 0);
    cyc1();
    check_outs("warm2", 1, 0, 0, 0, 0);
    cyc1();
    check_outs("track0", 1, 1, 1, 0, 0);

    // Ramp up to 40; the accept lands on a tick edge and uses old target 0
    send(40);
    check_outs("acc40", 1, 1, 1, 0, 1);
    wait_tick();
    check("ramp16", {19'b0, dac_distance}, 32'd16);
    wait_tick();
    check("ramp32", {19'b0, dac_distance}, 32'd32);
    exp_dac = 32;
    track_ticks("ramp40", 40, 1);
    check("busy40", {31'b0, busy}, 32'd0);

    // New target 10 accepted on a tick edge: that tick still steps toward 40
    repeat (3) cyc1();
    send(10);
    check_outs("acc10_tick", 1, 1, 1, 40, 1);
    wait_tick();
    check("down24", {19'b0, dac_distance}, 32'd24);
    wait_tick();
    check("down10", {19'b0, dac_distance}, 32'd10);
    check("busy10", {31'b0, busy}, 32'd0);
    exp_dac = 10;

    // Out-of-range sample clamps to full scale and holds there
    track_ticks("up_full", 5000, 130);
    check_outs("full_hold", 1, 1, 1, 2048, 0);
    track_ticks("down40", 40, 126);

    // Timeout into MUTE and back to TRACK
    send(40);
    wait_tick();
    check("to_tick1.in_ready", {31'b0, in_ready}, 32'd1);
    wait_tick();
    check("to_tick2.in_ready", {31'b0, in_ready}, 32'd1);
    wait_tick();
    check_outs("to_mute", 1, 1, 0, 40, 1);
    wait_tick();
    check_outs("mute24", 1, 1, 0, 24, 1);
    wait_tick();
    check_outs("mute8", 1, 1, 0, 8, 1);
    wait_tick();
    check_outs("mute0", 1, 1, 0, 0, 0);
    cyc1();
    check_outs("retrack", 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      wait_tick();
      check_outs("idle_track", 1, 1, 1, 0, 0);
    end
    exp_dac = 0;

    // run drops on a tick edge with a sample offered
    track_ticks("up32", 32, 2);
    repeat (3) cyc1();
    run = 1'b0; in_valid = 1'b1; in_distance = 13'd500;
    #1;
    check("run0.in_ready", {31'b0, in_ready}, 32'd0);
    cyc1();
    in_valid = 1'b0;
    check_outs("run0_mute", 1, 1, 0, 32, 1);
    wait_tick();
    check_outs("run0_16", 1, 1, 0, 16, 1);
    wait_tick();
    check_outs("run0_0", 1, 1, 0, 0, 0);
    cyc1();
    check_outs("run0_idle", 0, 0, 0, 0, 0);

    // Reset mid-TRACK at 100, then warm-up again
    run = 1'b1;
    cyc1();
    cyc1();
    cyc1();
    check_outs("s6_track", 1, 1, 1, 0, 0);
    exp_dac = 0;
    track_ticks("up100", 100, 7);
    reset = 1'b1;
    #1;
    check_outs("mid_rst_high", 0, 0, 0, 0, 0);
    cyc1();
    check_outs("mid_rst_edge", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check_outs("mid_rst_after", 0, 0, 0, 0, 0);
    cyc1();
    check_outs("rewarm1", 1, 0, 0, 0, 0);
    cyc1();
    check_outs("rewarm2", 1, 0, 0, 0, 0);
    cyc1();
    check_outs("retrack2", 1, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
